conv_mac_scheduler: RTL and testbench

- Sequences the 3x3 floating-point convolution MAC datapath across one feature map.
- Walks every valid 3x3 window position in raster order and issues one window per cycle to the patch-fetch/MAC path.
- Tracks in-flight MAC results with a latency-matched valid pipe and buffers results in a small FIFO.
- Presents results with valid/ready backpressure and never overruns the FIFO.

---
 rtl/conv_sched_pkg.sv | 24 ++
 rtl/sched_result_fifo.sv | 47 ++++
 rtl/conv_mac_scheduler.sv | 166 ++++++++++++++++
 tb/tb_conv_mac_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and geometry helpers for the 3x3 convolution MAC scheduler.
package conv_sched_pkg;

   // Coordinates are stored at this fixed width inside the result FIFO.
   localparam int ENTRY_CW = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

   typedef struct packed {
      logic [31:0]         data;
      logic [ENTRY_CW-1:0] row;
      logic [ENTRY_CW-1:0] col;
      logic                last;
   } sched_entry_t;

   function automatic int out_dim(input int img_dim);
      return img_dim - 2;
   endfunction

   function automatic int frame_results(input int img_w, input int img_h);
      return out_dim(img_w) * out_dim(img_h);
   endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// First-word fall-through result FIFO with occupancy count; head reads as zero when empty.
module sched_result_fifo
   import conv_sched_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter type entry_t = sched_entry_t,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  entry_t        wr_entry,
   input  logic          rd_en,
   output entry_t        rd_entry,
   output logic          rd_valid,
   output logic [CW-1:0] count
);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign rd_valid = (count != '0);
   assign push     = wr_en && (count != CW'(DEPTH));
   assign pop      = rd_en && rd_valid;
   assign rd_entry = rd_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/conv_mac_scheduler.sv
// Walks every 3x3 window of a feature map in raster order, tracks MAC latency and
// buffers results behind a credit check so the result FIFO can never overflow.
module conv_mac_scheduler
   import conv_sched_pkg::*;
#(
   parameter int IMG_W       = 16,
   parameter int IMG_H       = 16,
   parameter int COORD_W     = 8,
   parameter int MAC_LATENCY = 6,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               win_issue,
   output logic [COORD_W-1:0] win_row,
   output logic [COORD_W-1:0] win_col,
   input  logic [31:0]        mac_result,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [31:0]        res_data,
   output logic [COORD_W-1:0] res_row,
   output logic [COORD_W-1:0] res_col,
   output logic               res_last
);

   localparam int                 OUT_W    = out_dim(IMG_W);
   localparam int                 OUT_H    = out_dim(IMG_H);
   localparam int                 CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(OUT_H - 1);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(OUT_W - 1);

   sched_state_t           state;
   logic [COORD_W-1:0]     cur_row;
   logic [COORD_W-1:0]     cur_col;
   logic                   win_last;
   logic                   at_last;
   logic [MAC_LATENCY-1:0] vld_pipe;
   logic [MAC_LATENCY-1:0] last_pipe;
   logic [COORD_W-1:0]     row_pipe [MAC_LATENCY];
   logic [COORD_W-1:0]     col_pipe [MAC_LATENCY];
   sched_entry_t           wr_entry;
   sched_entry_t           head;
   logic [CNT_W-1:0]       fifo_count;
   logic                   pop;
   logic                   pop_last;
   logic                   can_issue;
   int                     outstanding;

   assign at_last  = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
   assign pop      = res_valid && res_ready;
   assign pop_last = pop && head.last;

   // Everything that will occupy a FIFO slot after this edge: buffered entries not
   // leaving now, results in the latency pipe, and the window being issued right now.
   always_comb begin
      outstanding = int'(fifo_count) - int'(pop) + $countones(vld_pipe) + int'(win_issue);
      can_issue   = (outstanding < FIFO_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_issue <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
         win_last  <= 1'b0;
         cur_row   <= '0;
         cur_col   <= '0;
      end else begin
         done      <= 1'b0;
         win_issue <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= ISSUE;
                  busy    <= 1'b1;
                  cur_row <= '0;
                  cur_col <= '0;
               end
            end
            ISSUE: begin
               if (can_issue) begin
                  win_issue <= 1'b1;
                  win_row   <= cur_row;
                  win_col   <= cur_col;
                  win_last  <= at_last;
                  if (at_last) begin
                     state <= DRAIN;
                  end else if (cur_col == LAST_COL) begin
                     cur_col <= '0;
                     cur_row <= cur_row + COORD_W'(1);
                  end else begin
                     cur_col <= cur_col + COORD_W'(1);
                  end
               end
            end
            DRAIN: begin
               // The last entry is also the youngest, so its pop leaves nothing behind.
               if (pop_last && (vld_pipe == '0) && (fifo_count == CNT_W'(1))) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe[0]  <= win_issue;
         last_pipe[0] <= win_issue & win_last;
         for (int i = 1; i < MAC_LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      row_pipe[0] <= win_row;
      col_pipe[0] <= win_col;
      for (int i = 1; i < MAC_LATENCY; i++) begin
         row_pipe[i] <= row_pipe[i-1];
         col_pipe[i] <= col_pipe[i-1];
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = mac_result;
      wr_entry.row  = ENTRY_CW'(row_pipe[MAC_LATENCY-1]);
      wr_entry.col  = ENTRY_CW'(col_pipe[MAC_LATENCY-1]);
      wr_entry.last = last_pipe[MAC_LATENCY-1];
   end

   sched_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (sched_entry_t)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (vld_pipe[MAC_LATENCY-1]),
      .wr_entry (wr_entry),
      .rd_en    (res_ready),
      .rd_entry (head),
      .rd_valid (res_valid),
      .count    (fifo_count)
   );

   assign res_data = head.data;
   assign res_row  = COORD_W'(head.row);
   assign res_col  = COORD_W'(head.col);
   assign res_last = head.last;

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Bench for conv_mac_scheduler: three instances (5x5/depth 8, 3x3/depth 8, 5x5/depth 2)
// checked against a raster-order scoreboard and a tagging MAC model.
module tb_conv_mac_scheduler;

   localparam int CW  = 8;
   localparam int NI  = 3;
   localparam int LAT = 6;

   function automatic int img(input int i);
      return (i == 1) ? 3 : 5;
   endfunction
   function automatic int ow(input int i);
      return img(i) - 2;
   endfunction
   function automatic int nres(input int i);
      return ow(i) * ow(i);
   endfunction
   function automatic int dp(input int i);
      return (i == 2) ? 2 : 8;
   endfunction
   function automatic logic [31:0] tag(input logic [7:0] r, input logic [7:0] c);
      return {16'h3F80, r, c};
   endfunction

   logic          clk = 1'b0;
   logic          reset;
   logic          start      [NI];
   logic          res_ready  [NI];
   logic [31:0]   mac_result [NI];
   logic          busy       [NI];
   logic          done       [NI];
   logic          win_issue  [NI];
   logic [CW-1:0] win_row    [NI];
   logic [CW-1:0] win_col    [NI];
   logic          res_valid  [NI];
   logic [31:0]   res_data   [NI];
   logic [CW-1:0] res_row    [NI];
   logic [CW-1:0] res_col    [NI];
   logic          res_last   [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      conv_mac_scheduler #(
         .IMG_W(img(g)), .IMG_H(img(g)), .COORD_W(CW),
         .MAC_LATENCY(LAT), .FIFO_DEPTH(dp(g))
      ) u_dut (
         .clk(clk), .reset(reset), .start(start[g]), .busy(busy[g]), .done(done[g]),
         .win_issue(win_issue[g]), .win_row(win_row[g]), .win_col(win_col[g]),
         .mac_result(mac_result[g]), .res_valid(res_valid[g]), .res_ready(res_ready[g]),
         .res_data(res_data[g]), .res_row(res_row[g]), .res_col(res_col[g]),
         .res_last(res_last[g])
      );
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard / monitor state per instance
   int          n_iss [NI], n_pop [NI], n_done [NI];
   int          first_iss [NI], last_iss [NI], first_pop [NI], last_pop_cyc [NI];
   logic        rec_v [NI][16];
   logic [7:0]  rec_r [NI][16], rec_c [NI][16];
   logic        hold [NI];
   logic [31:0] h_d [NI];
   logic [7:0]  h_r [NI], h_c [NI];
   logic        h_l [NI];

   task automatic clear_stats(input int i);
      n_iss[i] = 0; n_pop[i] = 0; n_done[i] = 0;
      first_iss[i] = -1; last_iss[i] = -1; first_pop[i] = -1; last_pop_cyc[i] = -100;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // MAC model: the result seen LAT cycles after an issue carries that window's tag.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int k;
         int j;
         rec_v[i][cyc % 16] = win_issue[i];
         rec_r[i][cyc % 16] = win_row[i];
         rec_c[i][cyc % 16] = win_col[i];
         j = (cyc - LAT) % 16;
         if (cyc >= LAT && rec_v[i][j]) mac_result[i] = tag(rec_r[i][j], rec_c[i][j]);
         else                           mac_result[i] = 32'hDEAD_0000 + 32'(cyc);
         if (reset) begin
            hold[i] = 1'b0;
         end else begin
            if (win_issue[i]) begin
               chk("issue_row", win_row[i], n_iss[i] / ow(i));
               chk("issue_col", win_col[i], n_iss[i] % ow(i));
               if (n_iss[i] == 0) first_iss[i] = cyc;
               last_iss[i] = cyc;
               n_iss[i]++;
            end
            if (n_iss[i] > 0) chk("outstanding_le_depth", longint'((n_iss[i] - n_pop[i]) <= dp(i)), 1);
            if (hold[i]) begin
               chk("hold_valid", res_valid[i], 1);
               chk("hold_data", res_data[i], h_d[i]);
               chk("hold_row", res_row[i], h_r[i]);
               chk("hold_col", res_col[i], h_c[i]);
               chk("hold_last", res_last[i], h_l[i]);
            end
            hold[i] = res_valid[i] && !res_ready[i];
            h_d[i] = res_data[i]; h_r[i] = res_row[i]; h_c[i] = res_col[i]; h_l[i] = res_last[i];
            if (res_valid[i] && res_ready[i]) begin
               k = n_pop[i];
               chk("res_row", res_row[i], k / ow(i));
               chk("res_col", res_col[i], k % ow(i));
               chk("res_data", res_data[i], tag(8'(k / ow(i)), 8'(k % ow(i))));
               chk("res_last", res_last[i], longint'(k == nres(i) - 1));
               if (k == 0) first_pop[i] = cyc;
               last_pop_cyc[i] = cyc;
               n_pop[i]++;
            end
            if (done[i]) begin
               n_done[i]++;
               chk("done_after_last_pop", cyc, last_pop_cyc[i] + 1);
               chk("busy_low_at_done", busy[i], 0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int i);
      start[i] = 1'b1;
      step();
      start[i] = 1'b0;
   endtask

   // mode 0: always ready, 1: toggling, 2: random (mostly ready)
   task automatic run_frame(input int i, input int mode);
      clear_stats(i);
      pulse_start(i);
      for (int t = 0; t < 600 && n_done[i] == 0; t++) begin
         case (mode)
            0:       res_ready[i] = 1'b1;
            1:       res_ready[i] = (t % 2 == 0);
            default: res_ready[i] = ($urandom_range(0, 3) != 0);
         endcase
         step();
      end
      res_ready[i] = 1'b1;
      repeat (4) step();
   endtask

   task automatic check_quiet_outputs(input int i, input string name);
      chk({name, "_ctrl"}, {busy[i], done[i], win_issue[i], res_valid[i], res_last[i]}, 0);
      chk({name, "_win"}, {win_row[i], win_col[i]}, 0);
      chk({name, "_res"}, {res_data[i], res_row[i], res_col[i]}, 0);
   endtask

   typedef struct {
      int inst;
      int mode;
      int exp_iss;
      int exp_pop;
      int exp_span;  // -1: not checked
      int exp_lat;   // first pop minus first issue, -1: not checked
   } vec_t;

   vec_t vt [8];

   initial begin
      vt = '{
         '{0, 0, 9, 9,  8,  7},
         '{1, 0, 1, 1,  0,  7},
         '{2, 1, 9, 9, -1, -1},
         '{2, 0, 9, 9, -1,  7},
         '{0, 2, 9, 9, -1, -1},
         '{0, 1, 9, 9, -1, -1},
         '{2, 2, 9, 9, -1, -1},
         '{1, 2, 1, 1, -1, -1}
      };
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
         start[i] = 1'b0;
         res_ready[i] = 1'b1;
         hold[i] = 1'b0;
         clear_stats(i);
      end
      repeat (3) step();
      for (int i = 0; i < NI; i++) check_quiet_outputs(i, "reset_state");
      reset = 1'b0;
      step();

      for (int v = 0; v < 8; v++) begin
         run_frame(vt[v].inst, vt[v].mode);
         chk("tbl_issues", n_iss[vt[v].inst], vt[v].exp_iss);
         chk("tbl_pops", n_pop[vt[v].inst], vt[v].exp_pop);
         chk("tbl_done_count", n_done[vt[v].inst], 1);
         chk("tbl_busy_idle", busy[vt[v].inst], 0);
         if (vt[v].exp_span >= 0)
            chk("tbl_issue_span", last_iss[vt[v].inst] - first_iss[vt[v].inst], vt[v].exp_span);
         if (vt[v].exp_lat >= 0)
            chk("tbl_first_latency", first_pop[vt[v].inst] - first_iss[vt[v].inst], vt[v].exp_lat);
      end

      // Backpressure: credit stops issue with the FIFO full and the head parked.
      clear_stats(0);
      res_ready[0] = 1'b0;
      pulse_start(0);
      repeat (30) step();
      chk("bp_issues", n_iss[0], 8);
      chk("bp_win_issue_low", win_issue[0], 0);
      chk("bp_no_pops", n_pop[0], 0);
      chk("bp_head_valid", res_valid[0], 1);
      chk("bp_head_rowcol", {res_row[0], res_col[0]}, 0);
      chk("bp_head_data", res_data[0], tag(8'd0, 8'd0));
      chk("bp_busy", busy[0], 1);
      res_ready[0] = 1'b1;
      for (int t = 0; t < 100 && n_done[0] == 0; t++) step();
      repeat (3) step();
      chk("bp_issues_final", n_iss[0], 9);
      chk("bp_pops_final", n_pop[0], 9);
      chk("bp_done", n_done[0], 1);

      // A start while busy is ignored.
      clear_stats(0);
      pulse_start(0);
      repeat (4) step();
      chk("ign_busy", busy[0], 1);
      pulse_start(0);
      for (int t = 0; t < 100 && n_done[0] == 0; t++) step();
      repeat (20) step();
      chk("ign_issues", n_iss[0], 9);
      chk("ign_pops", n_pop[0], 9);
      chk("ign_done", n_done[0], 1);
      chk("ign_busy_after", busy[0], 0);

      // Reset mid-frame drops everything; the following frame restarts at (0,0).
      clear_stats(0);
      pulse_start(0);
      for (int t = 0; t < 50 && n_iss[0] < 4; t++) step();
      chk("rst_reached_4_issues", longint'(n_iss[0] >= 4), 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_quiet_outputs(0, "rst_mid");
      clear_stats(0);
      step();
      reset = 1'b0;
      repeat (15) step();
      chk("rst_no_stale_pops", n_pop[0], 0);
      chk("rst_no_stale_issues", n_iss[0], 0);
      chk("rst_no_done", n_done[0], 0);
      run_frame(0, 0);
      chk("rst_new_issues", n_iss[0], 9);
      chk("rst_new_pops", n_pop[0], 9);
      chk("rst_new_done", n_done[0], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
